// File: rtl/pl0_decode_if.sv
// rtl/pl0_decode_if.sv - stall codes and the fetch/decode bundle
//
// pl0_pkg         : stall-request codes shared by fetch and decode.
// pl0_decode_if   : instruction from fetch plus every decode output.
//   master modport : fetch/execute side (drives i_instr_val)
//   slave modport  : decode stage (drives all o_* signals)

package pl0_pkg;
  typedef enum logic [2:0] {
    PL0_STALL_NONE     = 3'd0,
    PL0_STALL_IMM      = 3'd1,
    PL0_STALL_1        = 3'd2,
    PL0_STALL_1_ALU    = 3'd3,
    PL0_STALL_1_BRANCH = 3'd4
  } pl0_stall_state;
endpackage

interface pl0_decode_if #(parameter int XLEN = 32);
  import pl0_pkg::*;

  logic [XLEN-1:0] i_instr_val;
  pl0_stall_state  o_stall_state;
  logic            o_funct3_2XOR0;
  logic [XLEN-1:0] o_imm_val;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [4:0]      o_rd;
  logic [3:0]      o_alu_ctrl;
  logic            o_alu_src_imm;
  logic [1:0]      o_alu_src_a;
  logic            o_reg_wr_en;
  logic [1:0]      o_wb_sel;
  logic            o_mem_rd;
  logic            o_mem_wr;
  logic            o_illegal;
  logic [31:0]     o_retired;

  modport master (
    output i_instr_val,
    input  o_stall_state, o_funct3_2XOR0, o_imm_val, o_rs1, o_rs2, o_rd,
           o_alu_ctrl, o_alu_src_imm, o_alu_src_a, o_reg_wr_en, o_wb_sel,
           o_mem_rd, o_mem_wr, o_illegal, o_retired
  );

  modport slave (
    input  i_instr_val,
    output o_stall_state, o_funct3_2XOR0, o_imm_val, o_rs1, o_rs2, o_rd,
           o_alu_ctrl, o_alu_src_imm, o_alu_src_a, o_reg_wr_en, o_wb_sel,
           o_mem_rd, o_mem_wr, o_illegal, o_retired
  );
endinterface

// File: rtl/pl0_decode.sv
// rtl/pl0_decode.sv - decode/control stage with one-cycle hold for multi-cycle ops
//
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : pl0_decode_if.slave - instruction in, register addresses,
//            immediate, ALU/memory/writeback controls, stall request,
//            sticky illegal flag and retired-instruction counter out

module pl0_decode
  import pl0_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pl0_decode_if.slave   bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic {ST_ISSUE, ST_HOLD} state_t;

  state_t         state_q, state_d;
  logic [31:0]    latch_q, latch_d;
  logic [31:0]    retired_q;
  logic           illegal_q;

  logic           hold, legal, rd_nz, multi, retire, set_illegal;
  logic [31:0]    raw, ins, imm;
  logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]     f3;
  logic [3:0]     alu_ctrl;
  logic [1:0]     src_a, wb_sel;
  logic           src_imm, wr_en, mem_rd, mem_wr, f3x;
  pl0_stall_state stall_cls;

  always_comb begin
    hold = (state_q == ST_HOLD);
    // While the PC is frozen the fetch bus still shows a word; only the latched copy counts.
    raw  = hold ? latch_q : bus.i_instr_val[31:0];

    legal = 1'b0;
    case (raw[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: legal = 1'b1;
      default: legal = 1'b0;
    endcase

    // Unsupported opcodes are decoded exactly like ADDI x0,x0,0.
    ins   = legal ? raw : NOP;
    f3    = ins[14:12];
    rd_nz = |ins[11:7];

    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'h000};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    stall_cls = PL0_STALL_NONE;
    multi     = 1'b0;
    imm       = 32'h0;
    alu_ctrl  = ALU_ADD;
    src_imm   = 1'b0;
    src_a     = 2'd0;
    wr_en     = 1'b0;
    wb_sel    = 2'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    f3x       = 1'b0;

    case (ins[6:0])
      OPC_OP: begin
        alu_ctrl = {ins[30], f3};
        wr_en    = rd_nz;
      end
      OPC_OP_IMM: begin
        // funct7[5] only distinguishes SRAI from SRLI among immediates.
        alu_ctrl = {(f3 == 3'b101) & ins[30], f3};
        imm      = imm_i;
        src_imm  = 1'b1;
        wr_en    = rd_nz;
      end
      OPC_LUI: begin
        imm     = imm_u;
        src_imm = 1'b1;
        src_a   = 2'd1;
        wr_en   = rd_nz;
      end
      OPC_AUIPC: begin
        imm     = imm_u;
        src_imm = 1'b1;
        src_a   = 2'd2;
        wr_en   = rd_nz;
      end
      OPC_JAL: begin
        stall_cls = PL0_STALL_IMM;
        imm       = imm_j;
        wb_sel    = 2'd2;
        wr_en     = rd_nz;
      end
      OPC_JALR: begin
        // Target = rs1 + imm; execute masks bit 0 of the sum.
        stall_cls = PL0_STALL_1_ALU;
        multi     = 1'b1;
        imm       = imm_i;
        src_imm   = 1'b1;
        wb_sel    = 2'd2;
        wr_en     = hold & rd_nz;
      end
      OPC_BRANCH: begin
        stall_cls = PL0_STALL_1_BRANCH;
        multi     = 1'b1;
        imm       = imm_b;
        f3x       = f3[2] ^ f3[0];
        case (f3[2:1])
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        stall_cls = PL0_STALL_1;
        multi     = 1'b1;
        imm       = imm_i;
        src_imm   = 1'b1;
        mem_rd    = 1'b1;
        wb_sel    = 2'd1;
        wr_en     = hold & rd_nz;
      end
      OPC_STORE: begin
        imm     = imm_s;
        src_imm = 1'b1;
        mem_wr  = 1'b1;
      end
      default: ;
    endcase

    state_d     = state_q;
    latch_d     = latch_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    if (hold) begin
      state_d = ST_ISSUE;
      retire  = 1'b1;
    end else if (multi) begin
      state_d = ST_HOLD;
      latch_d = ins;
    end else begin
      retire      = 1'b1;
      set_illegal = ~legal;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_ISSUE;
      latch_q   <= NOP;
      retired_q <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      retired_q <= retired_q + {31'h0, retire};
      illegal_q <= illegal_q | set_illegal;
    end
  end

  assign bus.o_stall_state  = (i_rst || hold) ? PL0_STALL_NONE : stall_cls;
  assign bus.o_funct3_2XOR0 = f3x;
  assign bus.o_imm_val      = XLEN'($signed(imm));
  assign bus.o_rs1          = ins[19:15];
  assign bus.o_rs2          = ins[24:20];
  assign bus.o_rd           = ins[11:7];
  assign bus.o_alu_ctrl     = alu_ctrl;
  assign bus.o_alu_src_imm  = src_imm;
  assign bus.o_alu_src_a    = src_a;
  assign bus.o_reg_wr_en    = wr_en & ~i_rst;
  assign bus.o_wb_sel       = wb_sel;
  assign bus.o_mem_rd       = mem_rd & ~i_rst;
  assign bus.o_mem_wr       = mem_wr & ~i_rst;
  assign bus.o_illegal      = illegal_q;
  assign bus.o_retired      = retired_q;

endmodule

// File: tb/tb_pl0_decode.sv
// tb/tb_pl0_decode.sv - vector table, corner sequences and random run against a reference decoder
module tb_pl0_decode;
  import pl0_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  pl0_decode_if bus ();

  pl0_decode dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]    ins;
    pl0_stall_state st;
    logic [4:0]     rd;
    logic [31:0]    imm;
    logic           wr;
    logic           mrd;
    logic           mwr;
    logic [1:0]     wb;
    logic           src_imm;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input vec_t e);
    chk({tag, ".stall"},   32'(bus.o_stall_state), 32'(e.st));
    chk({tag, ".rd"},      32'(bus.o_rd),          32'(e.rd));
    chk({tag, ".imm"},     bus.o_imm_val,          e.imm);
    chk({tag, ".wr_en"},   32'(bus.o_reg_wr_en),   32'(e.wr));
    chk({tag, ".mem_rd"},  32'(bus.o_mem_rd),      32'(e.mrd));
    chk({tag, ".mem_wr"},  32'(bus.o_mem_wr),      32'(e.mwr));
    chk({tag, ".wb_sel"},  32'(bus.o_wb_sel),      32'(e.wb));
    chk({tag, ".src_imm"}, 32'(bus.o_alu_src_imm), 32'(e.src_imm));
  endtask

  function automatic bit is_legal(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [31:0] w);
    return (w[6:0] == 7'h63) || (w[6:0] == 7'h67) || (w[6:0] == 7'h03);
  endfunction

  // Reference decoder: immediates from field arithmetic, behaviour from the class rules.
  function automatic vec_t ref_dec(input logic [31:0] w, input bit hold);
    vec_t        e;
    logic [31:0] ii, si, bi, ui, ji;
    bit          nz;
    ii = 32'($signed(w) >>> 20);
    si = (w[31] ? 32'hFFFF_F800 : 32'h0) + 32'(w[30:25]) * 32 + 32'(w[11:7]);
    bi = (w[31] ? 32'hFFFF_F000 : 32'h0) + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
    ui = w & 32'hFFFF_F000;
    ji = (w[31] ? 32'hFFF0_0000 : 32'h0) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
    nz = (w[11:7] != 5'd0);
    e = '{ins: w, st: PL0_STALL_NONE, rd: w[11:7], imm: 32'h0, wr: 1'b0, mrd: 1'b0,
          mwr: 1'b0, wb: 2'd0, src_imm: 1'b0};
    case (w[6:0])
      7'h33: e.wr = nz;
      7'h13: begin e.wr = nz; e.imm = ii; e.src_imm = 1'b1; end
      7'h37, 7'h17: begin e.wr = nz; e.imm = ui; e.src_imm = 1'b1; end
      7'h6F: begin e.st = PL0_STALL_IMM; e.imm = ji; e.wb = 2'd2; e.wr = nz; end
      7'h67: begin
        e.st = hold ? PL0_STALL_NONE : PL0_STALL_1_ALU;
        e.imm = ii; e.src_imm = 1'b1; e.wb = 2'd2; e.wr = hold && nz;
      end
      7'h63: begin e.st = hold ? PL0_STALL_NONE : PL0_STALL_1_BRANCH; e.imm = bi; end
      7'h03: begin
        e.st = hold ? PL0_STALL_NONE : PL0_STALL_1;
        e.imm = ii; e.src_imm = 1'b1; e.mrd = 1'b1; e.wb = 2'd1; e.wr = hold && nz;
      end
      7'h23: begin e.imm = si; e.src_imm = 1'b1; e.mwr = 1'b1; end
      default: begin e.rd = 5'd0; e.src_imm = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  vec_t        vt[8];
  vec_t        e;
  logic [31:0] exp_ret;
  bit          m_hold, m_ill;
  logic [31:0] m_latch, m_ins, r;
  logic [6:0]  opc;

  initial begin
    vt[0] = '{32'h0050_0093, PL0_STALL_NONE, 5'd1,  32'h0000_0005, 1, 0, 0, 2'd0, 1};
    vt[1] = '{32'h0020_81B3, PL0_STALL_NONE, 5'd3,  32'h0000_0000, 1, 0, 0, 2'd0, 0};
    vt[2] = '{32'h1234_52B7, PL0_STALL_NONE, 5'd5,  32'h1234_5000, 1, 0, 0, 2'd0, 1};
    vt[3] = '{32'hFFFF_F017, PL0_STALL_NONE, 5'd0,  32'hFFFF_F000, 0, 0, 0, 2'd0, 1};
    vt[4] = '{32'hFE20_AE23, PL0_STALL_NONE, 5'd28, 32'hFFFF_FFFC, 0, 0, 1, 2'd0, 1};
    vt[5] = '{32'h0100_00EF, PL0_STALL_IMM,  5'd1,  32'h0000_0010, 1, 0, 0, 2'd2, 0};
    vt[6] = '{32'hFFFF_F06F, PL0_STALL_IMM,  5'd0,  32'hFFFF_FFFE, 0, 0, 0, 2'd2, 0};
    vt[7] = '{32'hFFFF_CF93, PL0_STALL_NONE, 5'd31, 32'hFFFF_FFFF, 1, 0, 0, 2'd0, 1};

    bus.i_instr_val = 32'h0050_0093;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.stall",   32'(bus.o_stall_state), 32'(PL0_STALL_NONE));
    chk("rst.wr_en",   32'(bus.o_reg_wr_en),   32'h0);
    chk("rst.retired", bus.o_retired,          32'h0);
    chk("rst.illegal", 32'(bus.o_illegal),     32'h0);
    i_rst = 1'b0;

    // Single-cycle classes from the vector table
    exp_ret = 0;
    for (int i = 0; i < 8; i++) begin
      bus.i_instr_val = vt[i].ins;
      #3;
      chk_dec($sformatf("vec%0d", i), vt[i]);
      tick();
      exp_ret++;
      chk($sformatf("vec%0d.retired", i), bus.o_retired, exp_ret);
    end
    chk("vec.illegal", 32'(bus.o_illegal), 32'h0);

    // BEQ, BNE re-presented in HOLD (must be ignored), then BNE decoded, then BLT
    bus.i_instr_val = 32'h0000_0463; #3;
    chk("beq.c0.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_1_BRANCH));
    chk("beq.c0.wr_en", 32'(bus.o_reg_wr_en), 32'h0);
    chk("beq.c0.imm",   bus.o_imm_val, 32'h8);
    tick();
    chk("beq.c0.retired", bus.o_retired, exp_ret);
    bus.i_instr_val = 32'h0000_1463; #3;
    chk("beq.c1.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_NONE));
    chk("beq.c1.f3x",   32'(bus.o_funct3_2XOR0), 32'h0);
    chk("beq.c1.imm",   bus.o_imm_val, 32'h8);
    chk("beq.c1.alu",   32'(bus.o_alu_ctrl), 32'h8);
    chk("beq.c1.src",   32'(bus.o_alu_src_imm), 32'h0);
    tick();
    exp_ret++;
    chk("beq.c1.retired", bus.o_retired, exp_ret);
    #3;
    chk("bne.c0.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_1_BRANCH));
    tick();
    bus.i_instr_val = 32'h0000_4463; #3;
    chk("bne.c1.f3x",   32'(bus.o_funct3_2XOR0), 32'h1);
    chk("bne.c1.alu",   32'(bus.o_alu_ctrl), 32'h8);
    tick();
    exp_ret++;
    #3;
    chk("blt.c0.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_1_BRANCH));
    tick();
    #3;
    chk("blt.c1.alu",   32'(bus.o_alu_ctrl), 32'h2);
    chk("blt.c1.f3x",   32'(bus.o_funct3_2XOR0), 32'h1);
    tick();
    exp_ret++;

    // JAL: single cycle, next word decodes on the following cycle
    bus.i_instr_val = 32'h0100_00EF; #3;
    chk("jal.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_IMM));
    tick();
    exp_ret++;
    bus.i_instr_val = 32'h0050_0093; #3;
    chk("jal.next.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_NONE));
    chk("jal.next.rd",    32'(bus.o_rd), 32'h1);
    tick();
    exp_ret++;

    // LW with an illegal word on the bus during HOLD
    bus.i_instr_val = 32'h0000_A103; #3;
    chk("lw.c0.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_1));
    chk("lw.c0.wr_en", 32'(bus.o_reg_wr_en), 32'h0);
    tick();
    bus.i_instr_val = 32'hFFFF_FFFF; #3;
    chk("lw.c1.stall",  32'(bus.o_stall_state), 32'(PL0_STALL_NONE));
    chk("lw.c1.mem_rd", 32'(bus.o_mem_rd), 32'h1);
    chk("lw.c1.wb_sel", 32'(bus.o_wb_sel), 32'h1);
    chk("lw.c1.rd",     32'(bus.o_rd), 32'h2);
    chk("lw.c1.wr_en",  32'(bus.o_reg_wr_en), 32'h1);
    tick();
    exp_ret++;
    chk("lw.illegal", 32'(bus.o_illegal), 32'h0);
    chk("lw.retired", bus.o_retired, exp_ret);

    // JALR x0 then an illegal word; illegal stays set
    bus.i_instr_val = 32'h0000_8067; #3;
    chk("jalr.c0.stall", 32'(bus.o_stall_state), 32'(PL0_STALL_1_ALU));
    tick();
    #3;
    chk("jalr.c1.wr_en",  32'(bus.o_reg_wr_en), 32'h0);
    chk("jalr.c1.wb_sel", 32'(bus.o_wb_sel), 32'h2);
    tick();
    bus.i_instr_val = 32'hFFFF_FFFF;
    tick();
    chk("ill.set", 32'(bus.o_illegal), 32'h1);
    bus.i_instr_val = 32'h0050_0093;
    tick();
    chk("ill.sticky", 32'(bus.o_illegal), 32'h1);

    // Reset during the HOLD cycle of a load
    bus.i_instr_val = 32'h0000_A103;
    tick();
    i_rst = 1'b1; #2;
    chk("rsthold.stall",   32'(bus.o_stall_state), 32'(PL0_STALL_NONE));
    chk("rsthold.wr_en",   32'(bus.o_reg_wr_en), 32'h0);
    chk("rsthold.mem_rd",  32'(bus.o_mem_rd), 32'h0);
    chk("rsthold.retired", bus.o_retired, 32'h0);
    chk("rsthold.illegal", 32'(bus.o_illegal), 32'h0);
    tick();
    i_rst = 1'b0;
    bus.i_instr_val = 32'h0000_0463; #3;
    chk("rsthold.issue", 32'(bus.o_stall_state), 32'(PL0_STALL_1_BRANCH));
    tick();
    chk("rsthold.noretire", bus.o_retired, 32'h0);
    tick();

    // Random run against the reference decoder
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    m_hold = 1'b0; m_ill = 1'b0; m_latch = 32'h13; exp_ret = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 10))
        0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h37;  3: opc = 7'h17;
        4: opc = 7'h6F;  5: opc = 7'h67;  6: opc = 7'h63;  7: opc = 7'h03;
        8: opc = 7'h23;  9: opc = 7'h13;
        default: opc = (n < 150) ? 7'h13 : 7'h7F;
      endcase
      r = $urandom();
      m_ins = {r[31:7], opc};
      bus.i_instr_val = m_ins;
      #3;
      e = ref_dec(m_hold ? m_latch : m_ins, m_hold);
      chk_dec($sformatf("rnd%0d", n), e);
      if (m_hold) begin
        m_hold = 1'b0;
        exp_ret++;
      end else if (is_multi(m_ins)) begin
        m_hold  = 1'b1;
        m_latch = m_ins;
      end else begin
        exp_ret++;
        if (!is_legal(m_ins)) m_ill = 1'b1;
      end
      tick();
      chk($sformatf("rnd%0d.retired", n), bus.o_retired, exp_ret);
      chk($sformatf("rnd%0d.illegal", n), 32'(bus.o_illegal), 32'(m_ill));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
